// File: rtl/song_player.sv
// Autonomous Ode-to-Joy sequencer driving a one-hot key vector in the same format as the piano's sw input.
// Optional macro SONG_PLAYER_LOOP_EN: wrap back to the first note instead of stopping after the last one.
module song_player #(
  parameter int BEAT_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] keys,
  output logic       busy,
  output logic [3:0] idx,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [3:0]  LAST_IDX = 4'd14;
  localparam logic [26:0] LEN1     = 27'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [26:0] LEN2     = 27'(2 * BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [26:0] LEN3     = 27'(3 * BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [26:0] GAP_LEN  = 27'(GAP_CYCLES - 1);

  state_t      state, state_d;
  logic [3:0]  idx_d;
  logic [26:0] cnt, cnt_d;
  logic [7:0]  keys_d;
  logic        done_d;
  logic        start_q;
  logic        armed;
  logic        start_edge;

  // Note table: 1=C4 .. 8=C5
  function automatic logic [3:0] note_code(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd6, 4'd11, 4'd12: note_code = 4'd3;
      4'd2, 4'd5:                     note_code = 4'd4;
      4'd3, 4'd4:                     note_code = 4'd5;
      4'd7, 4'd10, 4'd13, 4'd14:      note_code = 4'd2;
      default:                        note_code = 4'd1;
    endcase
  endfunction

  function automatic logic [1:0] note_beats(input logic [3:0] i);
    note_beats = (i == LAST_IDX) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [26:0] play_len(input logic [3:0] i);
    case (note_beats(i))
      2'd2:    play_len = LEN2;
      2'd3:    play_len = LEN3;
      default: play_len = LEN1;
    endcase
  endfunction

  function automatic logic [7:0] key_of(input logic [3:0] i);
    key_of = 8'h80 >> (note_code(i) - 4'd1);
  endfunction

  // armed blocks the first cycle after reset so a start held high through
  // reset release is not mistaken for a fresh rising edge
  assign start_edge = start & ~start_q & armed;
  assign busy       = (state != IDLE);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    keys_d  = keys;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        keys_d = 8'h00;
        idx_d  = 4'd0;
        if (start_edge && !stop) begin
          state_d = PLAY;
          idx_d   = 4'd0;
          cnt_d   = play_len(4'd0);
          keys_d  = key_of(4'd0);
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = 4'd0;
          cnt_d   = 27'd0;
          keys_d  = 8'h00;
        end else if (cnt == 27'd0) begin
          state_d = GAP;
          keys_d  = 8'h00;
          cnt_d   = GAP_LEN;
        end else begin
          cnt_d = cnt - 27'd1;
        end
      end
      GAP: begin
        keys_d = 8'h00;
        if (stop) begin
          state_d = IDLE;
          idx_d   = 4'd0;
          cnt_d   = 27'd0;
        end else if (cnt == 27'd0) begin
          if (idx < LAST_IDX) begin
            state_d = PLAY;
            idx_d   = idx + 4'd1;
            cnt_d   = play_len(idx + 4'd1);
            keys_d  = key_of(idx + 4'd1);
          end else begin
            done_d = 1'b1;
            idx_d  = 4'd0;
`ifdef SONG_PLAYER_LOOP_EN
            state_d = PLAY;
            cnt_d   = play_len(4'd0);
            keys_d  = key_of(4'd0);
`else
            state_d = IDLE;
            cnt_d   = 27'd0;
`endif
          end
        end else begin
          cnt_d = cnt - 27'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
        cnt_d   = 27'd0;
        keys_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      idx     <= 4'd0;
      cnt     <= 27'd0;
      keys    <= 8'h00;
      done    <= 1'b0;
      start_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cnt     <= cnt_d;
      keys    <= keys_d;
      done    <= done_d;
      start_q <= start;
      armed   <= 1'b1;
    end
  end

endmodule
